sys_cmd_ctrl: RTL and testbench
===============================

# sys_cmd_ctrl

Parametrised single-clock command controller between the UART RX synchroniser, the register file, the ALU and the TX FIFO. It decodes byte-serial command frames, performs register writes, reads, ALU operations and multi-byte burst reads, and pushes response bytes into the TX FIFO with back-pressure. Burst reads and command-error reporting are new in this generation.

## Interface
- DATA_WIDTH, 8, byte/register width; ALU result is 2*DATA_WIDTH
- ADDR_WIDTH, 4, register-file address width
- FUNC_WIDTH, 4, ALU function code width
- BURST_MAX, 8, maximum burst-read length (1..2^ADDR_WIDTH)

- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- rx_data  in  DATA_WIDTH  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_en / rf_rd_en  out  1  one-cycle write / read strobes
- rf_wr_data  out  DATA_WIDTH  write data
- rf_rd_data  in  DATA_WIDTH  read data
- rf_rd_valid  in  1  read data valid
- alu_func  out  FUNC_WIDTH  ALU function
- alu_en  out  1  one-cycle ALU start strobe
- alu_clk_en  out  1  ALU clock-gate enable
- alu_out  in  2*DATA_WIDTH  ALU result
- alu_valid  in  1  ALU result valid
- tx_data  out  DATA_WIDTH  FIFO write data
- tx_wr  out  1  FIFO write strobe
- tx_full  in  1  FIFO full
- busy  out  1  frame in progress (state != IDLE)
- cmd_err  out  1  one-cycle error pulse

## Operation
- Frame opcodes (first byte): 0xAA write {addr, data}; 0xBB read {addr}; 0xCC ALU-with-operands {A, B, func}; 0xDD ALU-no-operands {func}; 0xEE burst read {addr, count}. Address/func fields take the low ADDR_WIDTH/FUNC_WIDTH bits of the byte.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUNC, ALU_WAIT, TX_LO, TX_HI, BR_ADDR, BR_CNT, BR_RD, BR_WAIT, BR_TX.
- IDLE: unknown opcode -> cmd_err pulse, stay IDLE.
- 0xAA: latch addr; on data byte, rf_wr_en=1 for one cycle with rf_addr/rf_wr_data -> IDLE.
- 0xBB: rf_rd_en one cycle -> RD_WAIT; on rf_rd_valid latch byte -> TX_LO (single byte) -> IDLE.
- 0xCC: A written to address 0 (rf_wr_en in OP_A), B to address 1 (OP_B), then func byte -> OP_FUNC behaviour.
- 0xDD / OP_FUNC: on func byte, alu_en one cycle, alu_func held until alu_valid -> latch result -> TX_LO (alu_out[DATA_WIDTH-1:0]) -> TX_HI (upper half) -> IDLE.
- alu_clk_en=1 from func-byte acceptance until alu_valid cycle inclusive, else 0.
- 0xEE: count 0 or >BURST_MAX -> cmd_err pulse, frame aborted -> IDLE. Else loop BR_RD (rf_rd_en) -> BR_WAIT (rf_rd_valid) -> BR_TX (push) for count bytes; address increments modulo 2^ADDR_WIDTH (wrap 0xF->0x0 at ADDR_WIDTH=4).
- TX push: tx_wr=1 only in a cycle with tx_full=0; tx_data stable from state entry until accepted; no byte dropped or duplicated.
- rx_valid while in RD_WAIT, ALU_WAIT, TX_*, BR_RD/WAIT/TX: byte dropped, cmd_err pulse, current frame continues.

## Timing
- Reset (RST sampled high at CLK edge): state IDLE; all outputs 0 next cycle, including tx_wr, rf_* strobes, alu_en, alu_clk_en, busy, cmd_err. Reset mid-frame abandons frame; no further strobes.
- Register-file write strobe in the cycle after the final frame byte's rx_valid.
- rf_rd_en one cycle after addr byte; response tx_wr earliest one cycle after rf_rd_valid.
- alu_en one cycle after func byte; TX_LO write earliest one cycle after alu_valid; TX_HI write earliest next cycle.
- Burst: at most one rf_rd_en outstanding; minimum 3 cycles per byte with tx_full=0.
- busy high from cycle after opcode acceptance until the cycle returning to IDLE.

## Test plan
- Frame AA,05,3C -> one rf_wr_en, rf_addr=5, rf_wr_data=0x3C; no tx_wr.
- Frame BB,05 with rf_rd_data=0x3C -> rf_rd_en once, single tx_wr tx_data=0x3C.
- Frame CC,0A,03,02 with alu_out=0x001E -> writes 0x0A@0, 0x03@1, alu_en with func=2, tx bytes 0x1E then 0x00; alu_clk_en low afterwards.
- Frame EE,0E,04 -> reads addresses E,F,0,1 in order, four tx bytes; tx_full held high 5 cycles mid-burst -> no loss, no duplicates.
- Opcode 0x55 and frame EE,00,00 -> one cmd_err pulse each, no rf/tx strobes, busy low after.
- RST asserted during ALU_WAIT -> all outputs 0 next cycle, later alu_valid ignored, next frame decoded normally.

Source files
------------

// File: rtl/sys_cmd_ctrl.sv
// Byte-serial command controller: decodes UART frames into register-file writes/reads,
// ALU operations and burst reads, and pushes response bytes into the TX FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for opcode byte
// WR_ADDR  | write frame, waiting for address byte
// WR_DATA  | write frame, waiting for data byte
// RD_ADDR  | read frame, waiting for address byte
// RD_WAIT  | read issued, waiting for rf_rd_valid
// OP_A     | ALU frame, waiting for operand A (to reg 0)
// OP_B     | ALU frame, waiting for operand B (to reg 1)
// OP_FUNC  | waiting for ALU function byte
// ALU_WAIT | ALU started, waiting for alu_valid
// TX_LO    | pushing read byte or ALU low byte
// TX_HI    | pushing ALU high byte
// BR_ADDR  | burst frame, waiting for start address
// BR_CNT   | burst frame, waiting for byte count
// BR_RD    | burst read strobe cycle
// BR_WAIT  | burst, waiting for rf_rd_valid
// BR_TX    | burst, pushing current byte
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUNC_WIDTH = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_valid,
  output logic [FUNC_WIDTH-1:0]   alu_func,
  output logic                    alu_en,
  output logic                    alu_clk_en,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_wr,
  input  logic                    tx_full,
  output logic                    busy,
  output logic                    cmd_err
);

  localparam logic [DATA_WIDTH-1:0] OPC_WR    = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OPC_RD    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU_O = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU   = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] OPC_BURST = DATA_WIDTH'(8'hEE);
  localparam logic [DATA_WIDTH-1:0] BURST_LIM = DATA_WIDTH'(BURST_MAX);
  localparam logic [DATA_WIDTH-1:0] ONE_BYTE  = DATA_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUNC,
    ALU_WAIT, TX_LO, TX_HI, BR_ADDR, BR_CNT, BR_RD, BR_WAIT, BR_TX
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]   res_hi_q;
  logic                    two_byte_q;
  logic                    tx_req_q;
  logic                    no_rx_st;

  // tx_req_q holds the pending byte; the write itself is gated by the live full flag
  assign tx_wr = tx_req_q & ~tx_full;
  assign busy  = (state != IDLE);

  assign no_rx_st = (state == RD_WAIT) || (state == ALU_WAIT) || (state == TX_LO) ||
                    (state == TX_HI) || (state == BR_RD) || (state == BR_WAIT) ||
                    (state == BR_TX);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      res_hi_q   <= '0;
      two_byte_q <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_data    <= '0;
      rf_addr    <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_wr_data <= '0;
      alu_func   <= '0;
      alu_en     <= 1'b0;
      alu_clk_en <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      cmd_err  <= 1'b0;
      if (rx_valid && no_rx_st)
        cmd_err <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              OPC_WR:    state <= WR_ADDR;
              OPC_RD:    state <= RD_ADDR;
              OPC_ALU_O: state <= OP_A;
              OPC_ALU:   state <= OP_FUNC;
              OPC_BURST: state <= BR_ADDR;
              default:   cmd_err <= 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (rx_valid) begin
            addr_q <= rx_data[ADDR_WIDTH-1:0];
            state  <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_valid) begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= addr_q;
            rf_wr_data <= rx_data;
            state      <= IDLE;
          end
        end
        RD_ADDR: begin
          if (rx_valid) begin
            rf_rd_en <= 1'b1;
            rf_addr  <= rx_data[ADDR_WIDTH-1:0];
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rf_rd_valid) begin
            tx_data    <= rf_rd_data;
            tx_req_q   <= 1'b1;
            two_byte_q <= 1'b0;
            state      <= TX_LO;
          end
        end
        OP_A: begin
          if (rx_valid) begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= '0;
            rf_wr_data <= rx_data;
            state      <= OP_B;
          end
        end
        OP_B: begin
          if (rx_valid) begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= ADDR_WIDTH'(1);
            rf_wr_data <= rx_data;
            state      <= OP_FUNC;
          end
        end
        OP_FUNC: begin
          if (rx_valid) begin
            alu_en     <= 1'b1;
            alu_clk_en <= 1'b1;
            alu_func   <= rx_data[FUNC_WIDTH-1:0];
            state      <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (alu_valid) begin
            alu_clk_en <= 1'b0;
            alu_func   <= '0;
            tx_data    <= alu_out[DATA_WIDTH-1:0];
            res_hi_q   <= alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_req_q   <= 1'b1;
            two_byte_q <= 1'b1;
            state      <= TX_LO;
          end
        end
        TX_LO: begin
          if (tx_wr) begin
            if (two_byte_q) begin
              tx_data <= res_hi_q;
              state   <= TX_HI;
            end else begin
              tx_req_q <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        TX_HI: begin
          if (tx_wr) begin
            tx_req_q <= 1'b0;
            state    <= IDLE;
          end
        end
        BR_ADDR: begin
          if (rx_valid) begin
            addr_q <= rx_data[ADDR_WIDTH-1:0];
            state  <= BR_CNT;
          end
        end
        BR_CNT: begin
          if (rx_valid) begin
            if (rx_data == '0 || rx_data > BURST_LIM) begin
              cmd_err <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt_q    <= rx_data;
              rf_rd_en <= 1'b1;
              rf_addr  <= addr_q;
              state    <= BR_RD;
            end
          end
        end
        BR_RD: state <= BR_WAIT;
        BR_WAIT: begin
          if (rf_rd_valid) begin
            tx_data  <= rf_rd_data;
            tx_req_q <= 1'b1;
            state    <= BR_TX;
          end
        end
        BR_TX: begin
          if (tx_wr) begin
            tx_req_q <= 1'b0;
            if (cnt_q == ONE_BYTE) begin
              state <= IDLE;
            end else begin
              cnt_q    <= cnt_q - ONE_BYTE;
              addr_q   <= addr_q + 1'b1;
              rf_addr  <= addr_q + 1'b1;
              rf_rd_en <= 1'b1;
              state    <= BR_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Randomised bench for sys_cmd_ctrl: transaction-level expectations per frame, with
// behavioural register-file, ALU and FIFO-full models around the controller.
module tb_sys_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [3:0]  rf_addr;
  logic        rf_wr_en, rf_rd_en;
  logic [7:0]  rf_wr_data;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic [3:0]  alu_func;
  logic        alu_en, alu_clk_en;
  logic [15:0] alu_out;
  logic        alu_valid;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_full;
  logic        busy, cmd_err;

  always #5 CLK = ~CLK;

  sys_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUNC_WIDTH(4), .BURST_MAX(8)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_func(alu_func), .alu_en(alu_en), .alu_clk_en(alu_clk_en),
    .alu_out(alu_out), .alu_valid(alu_valid), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .busy(busy), .cmd_err(cmd_err)
  );

  logic [7:0]  rf_mem  [16];
  logic [7:0]  ref_mem [16];
  logic [11:0] exp_wr[$], act_wr[$];
  logic [3:0]  exp_rd[$], act_rd[$];
  logic [3:0]  exp_alu[$], act_alu[$];
  logic [7:0]  exp_tx[$], act_tx[$];
  int          exp_err = 0, act_err = 0;
  int          n_chk = 0, n_pass = 0;
  int          rf_lat_max = 0, alu_lat = 0, alu_lat_max = 0;
  bit          full_rand = 1'b0, full_force = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [7:0] a,
                                         input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {b, a} ^ {12'h000, f};
    endcase
  endfunction

  // observe DUT transactions mid-cycle
  always @(negedge CLK) begin
    if (rf_wr_en) begin
      act_wr.push_back({rf_addr, rf_wr_data});
      rf_mem[rf_addr] = rf_wr_data;
    end
    if (rf_rd_en) act_rd.push_back(rf_addr);
    if (alu_en) begin
      act_alu.push_back(alu_func);
      chk("clk_en_at_start", 32'(alu_clk_en), 32'd1);
    end
    if (tx_wr) begin
      act_tx.push_back(tx_data);
      chk("wr_while_full", 32'(tx_full), 32'd0);
    end
    if (cmd_err) act_err++;
  end

  initial begin : rf_model
    logic [3:0] a;
    int lat;
    rf_rd_valid = 1'b0;
    rf_rd_data  = 8'h00;
    forever begin
      @(negedge CLK);
      if (rf_rd_en) begin
        a   = rf_addr;
        lat = int'($urandom_range(0, rf_lat_max));
        repeat (lat) @(posedge CLK);
        @(posedge CLK); #1;
        rf_rd_valid = 1'b1;
        rf_rd_data  = rf_mem[a];
        @(posedge CLK); #1;
        rf_rd_valid = 1'b0;
        rf_rd_data  = 8'($urandom);
      end
    end
  end

  initial begin : alu_model
    logic [3:0] f;
    int lat;
    alu_valid = 1'b0;
    alu_out   = 16'h0000;
    forever begin
      @(negedge CLK);
      if (alu_en) begin
        f   = alu_func;
        lat = alu_lat + int'($urandom_range(0, alu_lat_max));
        repeat (lat) @(posedge CLK);
        @(posedge CLK); #1;
        alu_valid = 1'b1;
        alu_out   = alu_fn(f, rf_mem[0], rf_mem[1]);
        @(posedge CLK); #1;
        alu_valid = 1'b0;
        alu_out   = 16'($urandom);
      end
    end
  end

  initial begin : full_model
    tx_full = 1'b0;
    forever begin
      @(posedge CLK); #1;
      tx_full = full_force || (full_rand && ($urandom_range(0, 2) == 0));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic fr_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA); send_byte(a); send_byte(d);
    exp_wr.push_back({a[3:0], d});
    ref_mem[a[3:0]] = d;
  endtask

  task automatic fr_read(input logic [7:0] a);
    send_byte(8'hBB); send_byte(a);
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(ref_mem[a[3:0]]);
  endtask

  task automatic push_alu(input logic [3:0] f);
    logic [15:0] r;
    r = alu_fn(f, ref_mem[0], ref_mem[1]);
    exp_alu.push_back(f);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
  endtask

  task automatic fr_alu_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
    exp_wr.push_back({4'h0, a});
    exp_wr.push_back({4'h1, b});
    ref_mem[0] = a;
    ref_mem[1] = b;
    push_alu(f[3:0]);
  endtask

  task automatic fr_burst(input logic [7:0] a, input logic [7:0] c);
    logic [3:0] ad;
    send_byte(8'hEE); send_byte(a); send_byte(c);
    if (c == 8'd0 || c > 8'd8) exp_err++;
    else for (int i = 0; i < int'(c); i++) begin
      ad = a[3:0] + 4'(i);
      exp_rd.push_back(ad);
      exp_tx.push_back(ref_mem[ad]);
    end
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (busy && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk($sformatf("%s busy_end", tag), 32'(busy), 32'd0);
    repeat (3) @(negedge CLK);
    chk($sformatf("%s wr_n", tag), 32'(act_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      chk($sformatf("%s wr[%0d]", tag, i), 32'(act_wr[i]), 32'(exp_wr[i]));
    chk($sformatf("%s rd_n", tag), 32'(act_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
      chk($sformatf("%s rd[%0d]", tag, i), 32'(act_rd[i]), 32'(exp_rd[i]));
    chk($sformatf("%s alu_n", tag), 32'(act_alu.size()), 32'(exp_alu.size()));
    for (int i = 0; i < exp_alu.size() && i < act_alu.size(); i++)
      chk($sformatf("%s alu[%0d]", tag, i), 32'(act_alu[i]), 32'(exp_alu[i]));
    chk($sformatf("%s tx_n", tag), 32'(act_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < act_tx.size(); i++)
      chk($sformatf("%s tx[%0d]", tag, i), 32'(act_tx[i]), 32'(exp_tx[i]));
    chk($sformatf("%s err", tag), 32'(act_err), 32'(exp_err));
    chk($sformatf("%s clk_en_idle", tag), 32'(alu_clk_en), 32'd0);
    exp_wr.delete(); act_wr.delete(); exp_rd.delete(); act_rd.delete();
    exp_alu.delete(); act_alu.delete(); exp_tx.delete(); act_tx.delete();
    exp_err = 0;
    act_err = 0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_func, alu_en, alu_clk_en,
                tx_data, tx_wr, busy, cmd_err});
  endfunction

  initial begin : main
    logic [7:0] op;
    int sel;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]  = 8'($urandom);
      ref_mem[i] = rf_mem[i];
    end

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs", all_outs(), 32'd0);
    RST = 1'b0;

    fr_write(8'h05, 8'h3C);               finish_frame("wr_05");
    fr_read(8'h05);                       finish_frame("rd_05");
    fr_alu_ops(8'h0A, 8'h03, 8'h02);      finish_frame("alu_ops");

    fr_burst(8'h0E, 8'h04);
    repeat (4) @(posedge CLK);
    #1 full_force = 1'b1;
    repeat (5) @(posedge CLK);
    #1 full_force = 1'b0;
    finish_frame("burst_wrap");

    send_byte(8'h55); exp_err++;          finish_frame("bad_opcode");
    fr_burst(8'h00, 8'h00);               finish_frame("burst_zero");
    fr_burst(8'h03, 8'h09);               finish_frame("burst_over");
    fr_burst(8'h07, 8'h08);               finish_frame("burst_max");

    // stray byte while the ALU is busy is dropped and flagged
    alu_lat = 10;
    send_byte(8'hDD); send_byte(8'h03); push_alu(4'h3);
    repeat (3) @(posedge CLK);
    send_byte(8'h77); exp_err++;
    finish_frame("stray_byte");

    // reset while waiting on the ALU; the late alu_valid must be ignored
    alu_lat = 8;
    send_byte(8'hDD); send_byte(8'h05); exp_alu.push_back(4'h5);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_alu_outputs", all_outs(), 32'd0);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    finish_frame("rst_mid_alu");
    alu_lat = 0;
    fr_read(8'h01);                       finish_frame("after_rst");

    full_rand   = 1'b1;
    rf_lat_max  = 3;
    alu_lat_max = 4;
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1: fr_write(8'($urandom), 8'($urandom));
        2, 3: fr_read(8'($urandom));
        4:    fr_alu_ops(8'($urandom), 8'($urandom), 8'($urandom));
        5: begin
          op = 8'($urandom);
          send_byte(8'hDD); send_byte(op); push_alu(op[3:0]);
        end
        6, 7: fr_burst(8'($urandom), 8'($urandom_range(0, 10)));
        default: begin
          op = 8'($urandom);
          if (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE}) op = 8'h55;
          send_byte(op); exp_err++;
        end
      endcase
      finish_frame($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
